// File: rtl/npc_pkg.sv
// Shared definitions for the ID-stage next-PC unit: control-transfer codes,
// the PC increment, the default reset vector and the branch-offset helper.
package npc_pkg;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BEQ     = 4'd1;
  localparam logic [3:0] BNE     = 4'd2;
  localparam logic [3:0] BLTZ    = 4'd3;
  localparam logic [3:0] BLEZ    = 4'd4;
  localparam logic [3:0] BGTZ    = 4'd5;
  localparam logic [3:0] BGEZ    = 4'd6;
  localparam logic [3:0] J       = 4'd7;
  localparam logic [3:0] JAL     = 4'd8;
  localparam logic [3:0] JR      = 4'd9;
  localparam logic [3:0] JALR    = 4'd10;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

  // Word offset of a conditional branch, sign-extended to a byte offset.
  function automatic logic signed [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc_ctrl_br_cond_sel.sv
// Maps the decoded control-transfer type and comparator flags to a
// redirect condition, and flags register-indirect jumps.
module br_cond_sel
  import npc_pkg::*;
(
  input  logic [3:0] br_type,
  input  logic       eq,
  input  logic       neq,
  input  logic       ltz,
  input  logic       lez,
  input  logic       gtz,
  input  logic       gez,
  output logic       cond,
  output logic       is_jr
);

  always_comb begin
    cond  = 1'b0;
    is_jr = 1'b0;
    case (br_type)
      BEQ:       cond = eq;
      BNE:       cond = neq;
      BLTZ:      cond = ltz;
      BLEZ:      cond = lez;
      BGTZ:      cond = gtz;
      BGEZ:      cond = gez;
      J, JAL:    cond = 1'b1;
      JR, JALR: begin
        cond  = 1'b1;
        is_jr = 1'b1;
      end
      default:   cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_ctrl.sv
// ID-stage next-PC unit: fetch PC register, branch/jump targets, link value
// and sticky misaligned-JR error. NPC_BRANCH_STATS_EN adds branch counters.
module npc_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          STAT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [3:0]        br_type,
  input  logic              eq,
  input  logic              neq,
  input  logic              ltz,
  input  logic              lez,
  input  logic              gtz,
  input  logic              gez,
  input  logic [31:0]       pc_id,
  input  logic [15:0]       imm16,
  input  logic [25:0]       index26,
  input  logic [31:0]       rs_data,
  output logic [31:0]       pc_if,
  output logic [31:0]       link_pc,
  output logic              taken,
  output logic              addr_err,
  output logic [31:0]       addr_err_pc
`ifdef NPC_BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] br_taken_cnt
`endif
);

  logic        cond;
  logic        is_jr;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] tgt;
  logic        err_set;

  logic [31:0] pc_q, pc_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] addr_err_pc_q, addr_err_pc_d;

  br_cond_sel u_cond (
    .br_type (br_type),
    .eq      (eq),
    .neq     (neq),
    .ltz     (ltz),
    .lez     (lez),
    .gtz     (gtz),
    .gez     (gez),
    .cond    (cond),
    .is_jr   (is_jr)
  );

  assign pc_plus4 = pc_id + PC_STEP;
  assign br_tgt   = pc_plus4 + br_offset(imm16);
  assign j_tgt    = {pc_plus4[31:28], index26, 2'b00};
  assign jr_tgt   = {rs_data[31:2], 2'b00};

  always_comb begin
    tgt = br_tgt;
    if (is_jr)
      tgt = jr_tgt;
    else if (br_type == J || br_type == JAL)
      tgt = j_tgt;
  end

  assign taken   = cond & ~stall;
  assign link_pc = pc_id + 32'd8;
  assign err_set = ~stall & is_jr & (rs_data[1:0] != 2'b00);

  // Misaligned JR/JALR still redirects to the word-aligned target.
  always_comb begin
    pc_d          = pc_q;
    addr_err_d    = addr_err_q | err_set;
    addr_err_pc_d = addr_err_pc_q;
    if (!stall)
      pc_d = taken ? tgt : pc_q + PC_STEP;
    if (err_set && !addr_err_q)
      addr_err_pc_d = pc_id;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= PC_RESET;
      addr_err_q    <= 1'b0;
      addr_err_pc_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      addr_err_q    <= addr_err_d;
      addr_err_pc_q <= addr_err_pc_d;
    end
  end

  assign pc_if       = pc_q;
  assign addr_err    = addr_err_q;
  assign addr_err_pc = addr_err_pc_q;

`ifdef NPC_BRANCH_STATS_EN
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
  logic [STAT_W-1:0] br_taken_cnt_q, br_taken_cnt_d;
  logic              is_xfer;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  assign is_xfer = ~stall & (br_type >= BEQ) & (br_type <= JALR);

  always_comb begin
    br_cnt_d       = is_xfer ? sat_inc(br_cnt_q) : br_cnt_q;
    br_taken_cnt_d = taken ? sat_inc(br_taken_cnt_q) : br_taken_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_cnt_q       <= '0;
      br_taken_cnt_q <= '0;
    end else begin
      br_cnt_q       <= br_cnt_d;
      br_taken_cnt_q <= br_taken_cnt_d;
    end
  end

  assign br_cnt       = br_cnt_q;
  assign br_taken_cnt = br_taken_cnt_q;
`endif

endmodule

// File: doc/npc_ctrl.md
Name: npc_ctrl

Overview:
- ID-stage next-PC unit of the five-stage MIPS pipeline; holds the architectural fetch PC register.
- Consumes the branch comparator flags (eq/neq/ltz/lez/gtz/gez), which are computed from the forwarded rs/rt values.
- Combines the flags with the decoded branch type to choose the next fetch address: sequential, branch, J/JAL, or JR/JALR.
- Single delay slot, no flush. Also produces the link value and a sticky misaligned-jump error.

Parameters:
- PC_RESET, 32'h0000_3000, fetch PC loaded on reset.
- STAT_W, 32, width of the optional statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall from the hazard unit; freezes the PC and ignores ID.
- br_type  in  4  decoded control-transfer type of the instruction in ID (codes in package).
- eq, neq, ltz, lez, gtz, gez  in  1 each  comparator flags for the instruction in ID.
- pc_id  in  32  PC of the instruction in ID.
- imm16  in  16  branch offset field.
- index26  in  26  J/JAL index field.
- rs_data  in  32  forwarded rs value (JR/JALR target).
- pc_if  out  32  current fetch PC (register).
- link_pc  out  32  pc_id+8, combinational; used for JAL/JALR write-back.
- taken  out  1  combinational; ID transfer redirects this cycle.
- addr_err  out  1  sticky misaligned JR/JALR target flag.
- addr_err_pc  out  32  pc_id of the first misaligned JR/JALR.
- br_cnt, br_taken_cnt  out  STAT_W each  present only with the optional feature.

Behaviour:
- Reset (async, while reset=0): pc_if=PC_RESET, addr_err=0, addr_err_pc=0, counters=0. Release is synchronous to the next rising edge.
- Condition by br_type:
  - BEQ uses eq; BNE uses neq; BLTZ/BLEZ/BGTZ/BGEZ use ltz/lez/gtz/gez.
  - J, JAL, JR, JALR are always taken.
  - NONE and reserved codes (11-15) are never taken.
- taken = condition AND NOT stall.
- Targets, all mod 2^32 with wrap-around and no overflow detection:
  - branch: pc_id + 4 + (sign_extend(imm16) << 2).
  - J/JAL: {pc_id_plus4[31:28], index26, 2'b00}.
  - JR/JALR: {rs_data[31:2], 2'b00}.
- Each rising edge:
  - stall=1: pc_if holds; no counter or error update.
  - stall=0 and taken: pc_if <= target.
  - stall=0 and not taken: pc_if <= pc_if + 4 (wraps FFFF_FFFC -> 0000_0000).
- Delay slot: while a branch is in ID, IF is already fetching pc_id+4; the target becomes pc_if one cycle later. No squash.
- addr_err: set when stall=0, br_type is JR or JALR, and rs_data[1:0] != 0.
  - On the first set, addr_err_pc <= pc_id. Later errors do not overwrite it.
  - Cleared only by reset. The PC still loads the aligned target.
- Simultaneous stall and taken: stall wins; no redirect.
- Reset mid-operation: immediate return to the reset values; no pending state survives.
- link_pc = pc_id + 8 regardless of stall.

Optional Feature:
- Macro: NPC_BRANCH_STATS_EN.
- Defined:
  - br_cnt increments on each unstalled cycle with br_type in BEQ..JALR.
  - br_taken_cnt increments when taken=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package npc_pkg holds:
  - the br_type localparams: BR_NONE=0, BEQ=1, BNE=2, BLTZ=3, BLEZ=4, BGTZ=5, BGEZ=6, J=7, JAL=8, JR=9, JALR=10;
  - PC_STEP=4;
  - the default reset vector.
- One sub-module, br_cond_sel: combinational br_type + flags -> condition, plus a jump-register indicator.
- PC register, target adders, error latch and counters stay in npc_ctrl.

Test Plan:
- Reset low with clocks running -> pc_if=0000_3000 throughout. After release, three edges with br_type=NONE -> 3004, 3008, 300C.
- pc_id=3010, BEQ, eq=1, imm16=FFFE -> taken=1; next pc_if=300C. Repeat with eq=0 -> pc_if+4.
- pc_id=3020, JAL, index26=0000C40 -> pc_if=0000_3100; link_pc=3028.
- JR with rs_data=0000_3042 -> pc_if=3040, addr_err=1, addr_err_pc=pc_id. A second misaligned JR from another PC -> addr_err_pc unchanged.
- stall=1 with BGEZ, gez=1 for 2 cycles -> pc_if frozen, taken=0. Stall drops -> redirect on that edge.
- reset asserted mid-sequence between edges -> pc_if=3000 immediately. With NPC_BRANCH_STATS_EN: 5 branches, 3 taken -> br_cnt=5, br_taken_cnt=3.
